// File: rtl/reg_load_sequencer.sv
// Write sequencer for the 32x32 register stack.
// Debounced step/fill buttons drive single or burst writes.
module reg_load_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Btn_Step,
  input  logic        Btn_Fill,
  input  logic [1:0]  Sel_Data,
  output logic        Write_Reg,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic [4:0]  R_Addr,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    FILL
  } state_e;

  localparam logic [DB_W-1:0] CntMax = DB_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 = step button, bit 1 = fill button
  logic [1:0]            btn;
  logic [1:0]            s1_q, s2_q;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0]            prv_q;
  logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic                  step_p, fill_p;

  state_e      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [4:0]  raddr_q, raddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pat;

  assign btn    = {Btn_Fill, Btn_Step};
  assign step_p = lvl_q[0] & ~prv_q[0];
  assign fill_p = lvl_q[1] & ~prv_q[1];

  // Pattern lookup from the data-select switches
  always_comb begin
    pat = 32'h1234_5678;
    unique case (Sel_Data)
      2'b00: pat = 32'h1234_5678;
      2'b01: pat = 32'hFFFF_FFFF;
      2'b10: pat = 32'hF0F0_F0F0;
      2'b11: pat = 32'h0000_007F;
    endcase
  end

  // Debounce: level flips only after a run of stable mismatches
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CntMax) lvl_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Synchronisers, debounce state and edge history
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      prv_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      prv_q <= lvl_q;
      cnt_q <= cnt_d;
    end
  end

  // Next state and registered write-port values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (fill_p) begin
          state_d = FILL;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          waddr_d = 5'd0;
          raddr_d = 5'd0;
          wdata_d = pat;
        end else if (step_p) begin
          state_d = STEP;
          we_d    = 1'b1;
          waddr_d = ptr_q;
          raddr_d = ptr_q;
          wdata_d = pat;
        end
      end
      STEP: begin
        state_d = IDLE;
        ptr_d   = ptr_q + 5'd1;
      end
      FILL: begin
        if (waddr_q == 5'd31) begin
          state_d = IDLE;
          ptr_d   = 5'd0;
        end else begin
          we_d    = 1'b1;
          busy_d  = 1'b1;
          waddr_d = waddr_q + 5'd1;
          raddr_d = waddr_q + 5'd1;
          // pattern + address grows by one per beat
          wdata_d = wdata_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign Write_Reg = we_q;
  assign Busy      = busy_q;
  assign W_Addr    = waddr_q;
  assign R_Addr    = raddr_q;
  assign W_Data    = wdata_q;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Bench for reg_load_sequencer.
// Scoreboard of expected writes, checked on each negedge.
module tb_reg_load_sequencer;

  localparam int D = 4;

  logic        CLK;
  logic        Reset;
  logic        Btn_Step;
  logic        Btn_Fill;
  logic [1:0]  Sel_Data;
  logic        Write_Reg;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [4:0]  R_Addr;
  logic        Busy;

  int          tests;
  int          failed;
  int          writes;
  int          busy_cnt;
  int          cyc;
  int          last_wr;
  logic [4:0]  ptr_m;
  logic [36:0] exp_q[$];

  reg_load_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .DB_W(4)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Btn_Step(Btn_Step),
    .Btn_Fill(Btn_Fill),
    .Sel_Data(Sel_Data),
    .Write_Reg(Write_Reg),
    .W_Addr(W_Addr),
    .W_Data(W_Data),
    .R_Addr(R_Addr),
    .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] pat(input logic [1:0] s);
    case (s)
      2'b00:   return 32'h1234_5678;
      2'b01:   return 32'hFFFF_FFFF;
      2'b10:   return 32'hF0F0_F0F0;
      default: return 32'h0000_007F;
    endcase
  endfunction

  task automatic tick();
    logic [36:0] e;
    @(negedge CLK);
    cyc++;
    if (Busy === 1'b1) busy_cnt++;
    if (Write_Reg === 1'b1) begin
      writes++;
      last_wr = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write addr=%0d data=%h",
                 W_Addr, W_Data);
      end else begin
        e = exp_q.pop_front();
        if ({W_Addr, W_Data} !== e || R_Addr !== W_Addr) begin
          failed++;
          $display("FAIL write got a=%0d d=%h r=%0d exp a=%0d d=%h",
                   W_Addr, W_Data, R_Addr, e[36:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic push_step();
    exp_q.push_back({ptr_m, pat(Sel_Data)});
    ptr_m = ptr_m + 5'd1;
  endtask

  task automatic push_fill(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({5'(i), pat(Sel_Data) + 32'(i)});
    ptr_m = 5'd0;
  endtask

  task automatic press(input bit fill, input int hold, input int after);
    if (fill) Btn_Fill = 1'b1;
    else Btn_Step = 1'b1;
    repeat (hold) tick();
    Btn_Fill = 1'b0;
    Btn_Step = 1'b0;
    repeat (after) tick();
  endtask

  task automatic check_drain(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outs(input string name);
    tests++;
    if (Write_Reg !== 1'b0 || W_Addr !== 5'd0 || W_Data !== 32'd0 ||
        R_Addr !== 5'd0 || Busy !== 1'b0) begin
      failed++;
      $display("FAIL %s we=%b wa=%0d wd=%h ra=%0d busy=%b exp all 0",
               name, Write_Reg, W_Addr, W_Data, R_Addr, Busy);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) tick();
    check_idle_outs("reset_low");
    Reset = 1'b1;
    repeat (5) tick();
    check_idle_outs("reset_release");
    tests++;
    if (writes != 0) begin
      failed++;
      $display("FAIL reset_writes got=%0d exp=0", writes);
    end
  endtask

  task automatic test_step();
    int w0;
    Sel_Data = 2'b00;
    w0 = writes;
    push_step();
    press(1'b0, 12, 12);
    check_drain("step_first");
    tests++;
    if (writes - w0 != 1) begin
      failed++;
      $display("FAIL step_count got=%0d exp=1", writes - w0);
    end
    tests++;
    if (W_Addr !== 5'd0 || W_Data !== 32'h1234_5678) begin
      failed++;
      $display("FAIL step_hold a=%0d d=%h exp a=0 d=12345678",
               W_Addr, W_Data);
    end
    for (int i = 1; i < 33; i++) begin
      push_step();
      press(1'b0, 12, 12);
    end
    check_drain("step_wrap");
    tests++;
    if (W_Addr !== 5'd0) begin
      failed++;
      $display("FAIL step_wrap_addr got=%0d exp=0", W_Addr);
    end
  endtask

  task automatic test_bounce();
    int w0;
    int edge_cyc;
    bit seen;
    Sel_Data = 2'b01;
    w0 = writes;
    for (int i = 0; i < 10; i++) begin
      Btn_Step = ~Btn_Step;
      repeat (2) tick();
    end
    tests++;
    if (writes != w0) begin
      failed++;
      $display("FAIL bounce_quiet got=%0d exp=0", writes - w0);
    end
    push_step();
    Btn_Step = 1'b1;
    edge_cyc = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (writes != w0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL bounce_timeout got=no_write exp=write");
    end else if (last_wr - edge_cyc < D + 2 ||
                 last_wr - edge_cyc > D + 3) begin
      failed++;
      $display("FAIL bounce_latency got=%0d exp=%0d..%0d",
               last_wr - edge_cyc, D + 2, D + 3);
    end
    repeat (10) tick();
    Btn_Step = 1'b0;
    repeat (12) tick();
    check_drain("bounce_drain");
    tests++;
    if (writes - w0 != 1) begin
      failed++;
      $display("FAIL bounce_count got=%0d exp=1", writes - w0);
    end
  endtask

  task automatic test_fill();
    int w0;
    Sel_Data = 2'b11;
    w0 = writes;
    busy_cnt = 0;
    push_fill(32);
    press(1'b1, 12, 40);
    check_drain("fill_drain");
    tests++;
    if (busy_cnt != 32 || writes - w0 != 32) begin
      failed++;
      $display("FAIL fill_len busy=%0d writes=%0d exp=32/32",
               busy_cnt, writes - w0);
    end
    push_step();
    press(1'b0, 12, 12);
    check_drain("fill_then_step");
  endtask

  task automatic test_back_to_back();
    int w0;
    Sel_Data = 2'b10;
    w0 = writes;
    push_fill(32);
    Btn_Step = 1'b1;
    Btn_Fill = 1'b1;
    repeat (12) tick();
    Btn_Step = 1'b0;
    repeat (10) tick();
    Sel_Data = 2'b01;
    Btn_Step = 1'b1;
    repeat (28) tick();
    Btn_Step = 1'b0;
    Btn_Fill = 1'b0;
    repeat (15) tick();
    check_drain("conflict_drain");
    tests++;
    if (writes - w0 != 32) begin
      failed++;
      $display("FAIL conflict_count got=%0d exp=32", writes - w0);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit hit;
    Sel_Data = 2'b00;
    push_fill(10);
    Btn_Fill = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (Write_Reg === 1'b1 && W_Addr === 5'd9) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      failed++;
      $display("FAIL midfill_timeout got=no_addr9 exp=addr9");
    end
    Reset = 1'b0;
    #1;
    tests++;
    if (Write_Reg !== 1'b0) begin
      failed++;
      $display("FAIL midfill_async got=%b exp=0", Write_Reg);
    end
    repeat (3) tick();
    Btn_Fill = 1'b0;
    tick();
    Reset = 1'b1;
    repeat (10) tick();
    check_idle_outs("midfill_after");
    check_drain("midfill_drain");
    ptr_m = 5'd0;
    push_step();
    press(1'b0, 12, 12);
    check_drain("midfill_step");
  endtask

  initial begin
    tests = 0;
    failed = 0;
    writes = 0;
    busy_cnt = 0;
    cyc = 0;
    last_wr = 0;
    ptr_m = 5'd0;
    Reset = 1'b0;
    Btn_Step = 1'b0;
    Btn_Fill = 1'b0;
    Sel_Data = 2'b00;
    test_reset();
    test_step();
    test_bounce();
    test_fill();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reg_load_sequencer.md
Name: reg_load_sequencer

Overview:
- Upstream write controller for the 32x32 register stack; turns two raw push-buttons and the 2-bit data-select switches into clean register-file write transactions.
- Debounces the buttons and generates single-step writes at an auto-incrementing address, or a 32-cycle burst fill of the whole register file.
- Outputs drive the register stack write port (Write_Reg, W_Addr, W_Data) and its read address, so the display stage shows the last word written.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable CLK cycles required before a debounced level changes (20 ms at 50 MHz).
- DB_W, 20, width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock; the register stack is clocked by the same CLK.
- Reset  in  1  asynchronous, active-low reset.
- Btn_Step  in  1  raw step button, asynchronous, bouncy.
- Btn_Fill  in  1  raw fill button, asynchronous, bouncy.
- Sel_Data  in  2  data pattern select switches.
- Write_Reg  out  1  register-file write enable, registered.
- W_Addr  out  5  register-file write address, registered.
- W_Data  out  32  register-file write data, registered.
- R_Addr  out  5  register-file read address; the last address written.
- Busy  out  1  high while a fill burst is in progress.

Behaviour:
- Reset (Reset=0, async): Write_Reg=0, W_Addr=0, W_Data=0, R_Addr=0, Busy=0, ptr=0, state=IDLE. Synchronisers, debounced levels and debounce counters all clear to 0. A reset asserted mid-fill aborts the burst and drops Write_Reg immediately.
- Input conditioning, per button:
  - 2-FF synchroniser.
  - Counter clears whenever the synced value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - A rising edge of the debounced level yields a 1-cycle pulse (step_p / fill_p).
- Pattern, from the Sel_Data value sampled at the start of each operation:
  - 00 -> 0x12345678
  - 01 -> 0xFFFFFFFF
  - 10 -> 0xF0F0F0F0
  - 11 -> 0x0000007F
- FSM state IDLE:
  - fill_p -> FILL. fill_p wins if step_p occurs in the same cycle; that step_p is discarded.
  - step_p alone -> STEP.
- FSM state STEP (one cycle):
  - Write_Reg=1, W_Addr=ptr, W_Data=pattern, R_Addr=ptr.
  - Next cycle: Write_Reg=0, ptr=ptr+1 (31 wraps to 0), return to IDLE.
- FSM state FILL:
  - Write_Reg=1 and Busy=1 for exactly 32 consecutive cycles.
  - W_Addr steps 0,1,...,31; W_Data=pattern+W_Addr (32-bit wrap); R_Addr follows W_Addr.
  - After address 31: Write_Reg=0, Busy=0, ptr=0, return to IDLE.
- Latency:
  - Step pulse at cycle n -> write visible at n+1.
  - Fill pulse at n -> writes occupy n+1..n+32; IDLE at n+33.
- While in STEP or FILL:
  - All step_p/fill_p pulses are ignored, not queued.
  - Sel_Data changes have no effect until the next operation starts.
- Holding a button produces exactly one pulse; release produces none.
- W_Addr, W_Data and R_Addr hold their last values while in IDLE.

Test Plan (bench overrides DEBOUNCE_CYCLES=4):
- Reset low 3 cycles, then high -> all outputs 0, Busy=0, no Write_Reg pulse.
- Sel_Data=00, clean Btn_Step press -> exactly one Write_Reg cycle with W_Addr=0, W_Data=0x12345678. A second press gives W_Addr=1. After 32 presses, the 33rd write uses W_Addr=0 (wrap).
- Btn_Step toggling every 2 cycles for 20 cycles, then stable high -> exactly one write, occurring DEBOUNCE_CYCLES+2..+3 cycles after the last edge; none during bounce.
- Sel_Data=11, Btn_Fill press -> Busy high 32 cycles; writes (0,0x7F),(1,0x80)...(31,0x9E); afterwards ptr=0, so the next step writes addr 0.
- Btn_Step pressed during fill, and Btn_Step/Btn_Fill debounced in the same cycle -> fill runs; no extra write before or after the burst; write count = 32.
- Reset asserted at burst cycle 10 (W_Addr=9) -> Write_Reg=0 within the same cycle; after release, all outputs 0 and IDLE; a step press writes addr 0.
